// File: rtl/operand_sequencer_pkg.sv
// Shared assembler constants: instruction formats, operand slot kinds and
// destinations, and the per-format slot layout.
package assembler_constants;

  typedef enum logic [1:0] {
    FMT_R    = 2'd0,
    FMT_I    = 2'd1,
    FMT_U    = 2'd2,
    FMT_NONE = 2'd3
  } fmt_t;

  typedef enum logic {
    SK_REG,
    SK_IMM
  } slot_kind_t;

  typedef enum logic [1:0] {
    DST_RD,
    DST_RS1,
    DST_RS2,
    DST_IMM
  } slot_dst_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_NL    = 8'h0A;

  // R = rd,rs1,rs2 ; I = rd,rs1,imm ; U = rd,imm
  function automatic slot_kind_t slot_kind(input fmt_t fmt, input logic [1:0] idx);
    case (fmt)
      FMT_I:   return (idx == 2'd2) ? SK_IMM : SK_REG;
      FMT_U:   return (idx == 2'd1) ? SK_IMM : SK_REG;
      default: return SK_REG;
    endcase
  endfunction

  function automatic slot_dst_t slot_dst(input fmt_t fmt, input logic [1:0] idx);
    case (idx)
      2'd1:    return (fmt == FMT_U) ? DST_IMM : DST_RS1;
      2'd2:    return (fmt == FMT_I) ? DST_IMM : DST_RS2;
      default: return DST_RD;
    endcase
  endfunction

  function automatic logic [1:0] slot_count(input fmt_t fmt);
    case (fmt)
      FMT_R, FMT_I: return 2'd3;
      FMT_U:        return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: decoder handshake, character stream, interpreter
// enables/responses and the decoded fields.
interface operand_sequencer_if #(
  parameter int unsigned IMM_WIDTH = 20
);
  logic                       start;
  assembler_constants::fmt_t  format;
  logic                       valid_data;
  logic                       new_character;
  logic [7:0]                 incoming_ascii;
  logic                       reg_valid;
  logic                       reg_done;
  logic                       reg_error;
  logic                       reg_busy;
  logic [4:0]                 reg_value;
  logic                       imm_valid;
  logic                       imm_done;
  logic                       imm_error;
  logic                       imm_busy;
  logic [IMM_WIDTH-1:0]       imm_value;
  logic [4:0]                 rd;
  logic [4:0]                 rs1;
  logic [4:0]                 rs2;
  logic [IMM_WIDTH-1:0]       imm;
  logic                       done;
  logic                       error;
  logic                       busy;

  modport slave (
    input  start, format, valid_data, new_character, incoming_ascii,
    input  reg_done, reg_error, reg_busy, reg_value,
    input  imm_done, imm_error, imm_busy, imm_value,
    output reg_valid, imm_valid, rd, rs1, rs2, imm, done, error, busy
  );

  modport master (
    output start, format, valid_data, new_character, incoming_ascii,
    output reg_done, reg_error, reg_busy, reg_value,
    output imm_done, imm_error, imm_busy, imm_value,
    input  reg_valid, imm_valid, rd, rs1, rs2, imm, done, error, busy
  );

endinterface

// File: rtl/operand_sequencer.sv
// Walks an instruction's operand slots, enabling the matching interpreter and
// committing each value to its destination field on the slot delimiter.
module operand_sequencer
  import assembler_constants::*;
#(
  parameter int unsigned IMM_WIDTH = 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  operand_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SLOT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  fmt_t                 fmt_q, fmt_d;
  logic [4:0]           rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [IMM_WIDTH-1:0] imm_q, imm_d;

  slot_kind_t kind;
  logic       act_done, act_err, act_busy;
  logic       last_slot, blank_skip, commit;

  assign kind       = slot_kind(fmt_q, slot_q);
  assign act_done   = (kind == SK_REG) ? bus.reg_done  : bus.imm_done;
  assign act_err    = (kind == SK_REG) ? bus.reg_error : bus.imm_error;
  assign act_busy   = (kind == SK_REG) ? bus.reg_busy  : bus.imm_busy;
  assign last_slot  = (slot_q == slot_count(fmt_q) - 2'd1);
  assign blank_skip = (bus.incoming_ascii == CH_SPACE) && !act_busy;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      fmt_q   <= FMT_NONE;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fmt_q   <= fmt_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fmt_d   = fmt_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    commit  = 1'b0;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          if (bus.format == FMT_NONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SLOT;
            slot_d  = '0;
            fmt_d   = bus.format;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_SLOT: begin
        // Abort beats interpreter error, which beats any delimiter commit.
        if (!bus.valid_data) begin
          state_d = S_IDLE;
        end else if (act_err) begin
          state_d = S_ERROR;
        end else if (bus.new_character && !blank_skip) begin
          if (bus.incoming_ascii == CH_NL) begin
            if (!last_slot) begin
              state_d = S_ERROR;
            end else if (act_done) begin
              commit  = 1'b1;
              state_d = S_DONE;
            end
          end else if (bus.incoming_ascii == CH_COMMA) begin
            if (last_slot) begin
              state_d = S_ERROR;
            end else if (act_done) begin
              commit = 1'b1;
              slot_d = slot_q + 2'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      case (slot_dst(fmt_q, slot_q))
        DST_RD:  rd_d  = bus.reg_value;
        DST_RS1: rs1_d = bus.reg_value;
        DST_RS2: rs2_d = bus.reg_value;
        default: imm_d = bus.imm_value;
      endcase
    end
  end

  assign bus.reg_valid = (state_q == S_SLOT) && (kind == SK_REG);
  assign bus.imm_valid = (state_q == S_SLOT) && (kind == SK_IMM);
  assign bus.done      = (state_q == S_DONE);
  assign bus.error     = (state_q == S_ERROR);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rd        = rd_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.imm       = imm_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: stub interpreters, directed table, corner-case
// sequences and randomized operand strings against a token-level model.
module tb_operand_sequencer;
  import assembler_constants::*;

  localparam int unsigned IW = 20;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  operand_sequencer_if #(.IMM_WIDTH(IW)) bus();

  operand_sequencer #(.IMM_WIDTH(IW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  // Stub interpreters: 'r' + decimal digits for registers, plain decimal for immediates.
  logic          r_busy, r_done, i_busy, i_done, force_rerr;
  logic [4:0]    r_val;
  logic [IW-1:0] i_val;

  assign bus.reg_busy  = r_busy;
  assign bus.reg_done  = r_done;
  assign bus.reg_error = force_rerr;
  assign bus.reg_value = r_val;
  assign bus.imm_busy  = i_busy;
  assign bus.imm_done  = i_done;
  assign bus.imm_error = 1'b0;
  assign bus.imm_value = i_val;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= 1'b0; r_done <= 1'b0; r_val <= '0;
    end else if (!bus.reg_valid) begin
      r_busy <= 1'b0; r_done <= 1'b0;
    end else if (bus.new_character) begin
      if (bus.incoming_ascii == "r") begin
        r_busy <= 1'b1; r_done <= 1'b0; r_val <= '0;
      end else if (bus.incoming_ascii >= "0" && bus.incoming_ascii <= "9" && r_busy) begin
        r_val  <= 5'(32'(r_val) * 10 + 32'(bus.incoming_ascii - "0"));
        r_done <= 1'b1;
      end else if (bus.incoming_ascii == "," || bus.incoming_ascii == "\n") begin
        r_busy <= 1'b0; r_done <= 1'b0;
      end
    end
  end

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      i_busy <= 1'b0; i_done <= 1'b0; i_val <= '0;
    end else if (!bus.imm_valid) begin
      i_busy <= 1'b0; i_done <= 1'b0;
    end else if (bus.new_character) begin
      if (bus.incoming_ascii >= "0" && bus.incoming_ascii <= "9") begin
        i_val  <= i_busy ? IW'(32'(i_val) * 10 + 32'(bus.incoming_ascii - "0"))
                         : IW'(bus.incoming_ascii - "0");
        i_busy <= 1'b1; i_done <= 1'b1;
      end else if (bus.incoming_ascii == "," || bus.incoming_ascii == "\n") begin
        i_busy <= 1'b0; i_done <= 1'b0;
      end
    end
  end

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int both_en = 0;

  always @(negedge clk_in) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.reg_valid === 1'b1 && bus.imm_valid === 1'b1) both_en++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input fmt_t f);
    @(posedge clk_in); #1;
    bus.start  = 1'b1;
    bus.format = f;
    @(posedge clk_in); #1;
    bus.start  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.incoming_ascii = s[i];
      bus.new_character  = 1'b1;
      @(posedge clk_in); #1;
      bus.new_character  = 1'b0;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic run_txn(input string tag, input fmt_t f, input string s,
                         input int e_done, input int e_err,
                         input int e_rd, input int e_rs1, input int e_rs2, input int e_imm);
    done_cnt = 0;
    pulse_start(f);
    send_str(s);
    repeat (4) @(negedge clk_in);
    check({tag, ".done"},  done_cnt,  e_done);
    check({tag, ".error"}, bus.error, e_err);
    check({tag, ".busy"},  bus.busy,  e_err);
    check({tag, ".rd"},    bus.rd,    e_rd);
    check({tag, ".rs1"},   bus.rs1,   e_rs1);
    check({tag, ".rs2"},   bus.rs2,   e_rs2);
    check({tag, ".imm"},   bus.imm,   e_imm);
  endtask

  typedef struct {
    fmt_t  fmt;
    string txt;
    int    e_done, e_err, rd, rs1, rs2, imm;
  } vec_t;

  vec_t tbl[7];

  // Field index per operand position: 0=rd 1=rs1 2=rs2 3=imm.
  int lay[3][3] = '{'{0, 1, 2}, '{0, 1, 3}, '{0, 3, 3}};
  int m_fld[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.format = FMT_NONE; bus.valid_data = 1'b1;
    bus.new_character = 1'b0; bus.incoming_ascii = 8'h00; force_rerr = 1'b0;
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.error", bus.error, 0);
    check("rst.reg_valid", bus.reg_valid, 0);
    check("rst.imm_valid", bus.imm_valid, 0);
    check("rst.fields", {bus.rd, bus.rs1, bus.rs2}, 0);
    check("rst.imm", bus.imm, 0);
    rst_in = 1'b0;

    tbl[0] = '{FMT_R,    "r01, r02,r31\n",  1, 0, 1,  2, 31, 0};
    tbl[1] = '{FMT_I,    "r05,r06,100\n",   1, 0, 5,  6, 31, 100};
    tbl[2] = '{FMT_U,    "  r10,4096\n",    1, 0, 10, 6, 31, 4096};
    tbl[3] = '{FMT_R,    "r01,r02\n",       0, 1, 1,  6, 31, 4096};
    tbl[4] = '{FMT_NONE, "",                1, 0, 1,  6, 31, 4096};
    tbl[5] = '{FMT_R,    "r07 , r08,r9\n",  1, 0, 7,  8, 9,  4096};
    tbl[6] = '{FMT_R,    "r01,r02,r03,",    0, 1, 1,  2, 9,  4096};
    for (int v = 0; v < 7; v++)
      run_txn($sformatf("tbl%0d", v), tbl[v].fmt, tbl[v].txt, tbl[v].e_done,
              tbl[v].e_err, tbl[v].rd, tbl[v].rs1, tbl[v].rs2, tbl[v].imm);

    // I-format: the immediate interpreter is enabled only for the third slot.
    pulse_start(FMT_I);
    send_str("r05,");
    @(negedge clk_in);
    check("ien.slot1.reg_valid", bus.reg_valid, 1);
    check("ien.slot1.imm_valid", bus.imm_valid, 0);
    send_str("r06,");
    @(negedge clk_in);
    check("ien.slot2.reg_valid", bus.reg_valid, 0);
    check("ien.slot2.imm_valid", bus.imm_valid, 1);
    send_str("7\n");
    repeat (3) @(negedge clk_in);
    check("ien.imm", bus.imm, 7);

    // start during the DONE cycle is ignored.
    done_cnt = 0;
    pulse_start(FMT_U);
    send_str("r3,9");
    bus.incoming_ascii = "\n"; bus.new_character = 1'b1;
    @(posedge clk_in); #1;
    bus.new_character = 1'b0;
    bus.start = 1'b1; bus.format = FMT_R;
    @(posedge clk_in); #1;
    bus.start = 1'b0;
    @(negedge clk_in);
    check("dstart.busy", bus.busy, 0);
    check("dstart.done_cnt", done_cnt, 1);
    check("dstart.rd", bus.rd, 3);
    check("dstart.imm", bus.imm, 9);

    // Interpreter error mid-slot.
    done_cnt = 0;
    pulse_start(FMT_R);
    send_str("r01,r0");
    force_rerr = 1'b1;
    @(posedge clk_in); #1;
    force_rerr = 1'b0;
    @(negedge clk_in);
    check("suberr.error", bus.error, 1);
    check("suberr.reg_valid", bus.reg_valid, 0);
    check("suberr.imm_valid", bus.imm_valid, 0);
    check("suberr.rd", bus.rd, 1);

    // valid_data drop mid-slot keeps partial writes.
    done_cnt = 0;
    pulse_start(FMT_R);
    send_str("r04,r1");
    bus.valid_data = 1'b0;
    @(posedge clk_in); #1;
    bus.valid_data = 1'b1;
    repeat (2) @(negedge clk_in);
    check("abort.busy", bus.busy, 0);
    check("abort.reg_valid", bus.reg_valid, 0);
    check("abort.done_cnt", done_cnt, 0);
    check("abort.rd", bus.rd, 4);
    check("abort.rs1", bus.rs1, 6);

    // Asynchronous reset mid-slot.
    pulse_start(FMT_R);
    send_str("r12,r1");
    @(negedge clk_in); #2;
    rst_in = 1'b1;
    #1;
    check("arst.busy", bus.busy, 0);
    check("arst.reg_valid", bus.reg_valid, 0);
    check("arst.rd", bus.rd, 0);
    check("arst.imm", bus.imm, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Randomized operand strings against the token model.
    m_fld = '{0, 0, 0, 0};
    for (int t = 0; t < 40; t++) begin
      fmt_t  f;
      string s;
      int    n, k, mode, commits, fi;
      int    vals[3];
      bit    is_imm;
      fi   = int'($urandom_range(0, 2));
      f    = (fi == 0) ? FMT_R : (fi == 1) ? FMT_I : FMT_U;
      n    = (f == FMT_U) ? 2 : 3;
      mode = int'($urandom_range(0, 3));
      k    = (mode == 0) ? int'($urandom_range(1, n - 1)) : n;
      s    = "";
      repeat ($urandom_range(0, 2)) s = {s, " "};
      for (int j = 0; j < k; j++) begin
        is_imm  = (f == FMT_I && j == 2) || (f == FMT_U && j == 1);
        vals[j] = is_imm ? int'($urandom_range(0, 1048575)) : int'($urandom_range(0, 31));
        s = {s, is_imm ? $sformatf("%0d", vals[j]) : $sformatf("r%0d", vals[j])};
        if ($urandom_range(0, 1) == 1) s = {s, " "};
        if (j < k - 1) s = {s, ","};
        else           s = {s, (mode == 1) ? "," : "\n"};
        if (j < k - 1 && $urandom_range(0, 1) == 1) s = {s, " "};
      end
      commits = (mode == 0) ? k - 1 : (mode == 1) ? n - 1 : n;
      for (int j = 0; j < commits; j++) m_fld[lay[fi][j]] = vals[j];
      run_txn($sformatf("rnd%0d", t), f, s, (mode >= 2) ? 1 : 0, (mode < 2) ? 1 : 0,
              m_fld[0], m_fld[1], m_fld[2], m_fld[3]);
    end

    check("enables_exclusive", both_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
